// File: rtl/comparator_seq.sv
// comparator_seq: sequential magnitude comparator that walks two WIDTH-bit
// operands CHUNK bits per clock, most significant chunk first, and stops
// at the first chunk that differs.
//
// Parameters
//   WIDTH : operand width in bits (must be a multiple of CHUNK)
//   CHUNK : bits compared per cycle (CHUNK == WIDTH gives single-cycle compare)
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   start       : accept a/b/signed_mode when idle
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   a, b        : operands, sampled only at acceptance
//   busy        : comparison in progress
//   done        : one-cycle pulse, result valid
//   great/equal/less : one-hot result, held until the next accepted start
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             great,
  output logic             equal,
  output logic             less
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               smode_q, smode_d;
  logic               great_q, great_d;
  logic               equal_q, equal_d;
  logic               less_q, less_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [CHUNK-1:0]   ca, cb;
  logic               last_chunk;

  // Current chunk: shift the latched operands so chunk idx lands at the top.
  // In signed mode the sign bit of the top chunk is flipped, turning
  // two's-complement ordering into plain unsigned (offset-binary) ordering.
  always_comb begin
    a_sh = a_q << (CHUNK * int'(idx_q));
    b_sh = b_q << (CHUNK * int'(idx_q));
    ca   = a_sh[WIDTH-1 -: CHUNK];
    cb   = b_sh[WIDTH-1 -: CHUNK];
    if (smode_q && (idx_q == '0)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    last_chunk = (idx_q == IDX_W'(N - 1));
  end

  // State register (control flops reset asynchronously)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      great_q <= 1'b0;
      equal_q <= 1'b0;
      less_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      great_q <= great_d;
      equal_q <= equal_d;
      less_q  <= less_d;
      done_q  <= done_d;
    end
  end

  // Operand holding registers carry data only; they need no reset because
  // they are always reloaded on acceptance before being used.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    smode_q <= smode_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CMP;
      CMP:  if ((ca != cb) || last_chunk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / result next values
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    smode_d = smode_q;
    great_d = great_q;
    equal_d = equal_q;
    less_d  = less_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          smode_d = signed_mode;
          great_d = 1'b0;
          equal_d = 1'b0;
          less_d  = 1'b0;
          idx_d   = '0;
        end
      end
      CMP: begin
        if (ca > cb) begin
          great_d = 1'b1;
          done_d  = 1'b1;
        end else if (ca < cb) begin
          less_d  = 1'b1;
          done_d  = 1'b1;
        end else if (last_chunk) begin
          equal_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state_q == CMP);
    done  = done_q;
    great = great_q;
    equal = equal_q;
    less  = less_q;
  end

endmodule

// File: tb/tb_comparator_seq.sv
module tb_comparator_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             great;
  logic             equal;
  logic             less;

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .great       (great),
    .equal       (equal),
    .less        (less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] res;   // {great, equal, less}
    int         due;   // cycle count at which done is expected
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("onehot_max", 32'($countones({great, equal, less}) <= 1), 32'd1);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", 32'({great, equal, less}), 32'(e.res));
          check("latency_cycle", 32'(cyc), 32'(e.due));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic run(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input logic sm, input logic [2:0] res, input int lat);
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    push_exp(res, lat);
    @(negedge clk);
    start = 1'b0;
    drain("done_timeout");
    @(negedge clk);
    check("result_hold", 32'({great, equal, less}), 32'(res));
    check("done_one_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, great, equal, less}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({busy, done, great, equal, less}), 32'd0);

    // Directed comparisons
    run(16'd60000, 16'd60000, 1'b0, EQ, 4);
    run(16'h1388,  16'h0FA1,  1'b0, GT, 1);
    run(16'd2,     16'd4,     1'b0, LT, 4);
    run(16'hFFFF,  16'h0001,  1'b1, LT, 1);
    run(16'hFFFF,  16'h0001,  1'b0, GT, 1);
    run(16'h1234,  16'h1243,  1'b0, LT, 3);
    run(16'h0100,  16'h0000,  1'b0, GT, 2);
    run(16'hFFFF,  16'hFFFE,  1'b1, GT, 4);
    run(16'h8000,  16'h8000,  1'b1, EQ, 4);
    run(16'h7FFF,  16'h8000,  1'b1, GT, 1);

    // Operand change and start during CMP are ignored; back-to-back start in done cycle
    @(negedge clk);
    a = 16'd2; b = 16'd4; signed_mode = 1'b0; start = 1'b1;
    push_exp(LT, 4);
    @(negedge clk);
    start = 1'b0;
    check("busy_in_cmp", 32'(busy), 32'd1);
    @(negedge clk);
    a = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      check("ignore_done_seen", 32'(seen), 32'd1);
    end
    a = 16'd7; b = 16'd3; start = 1'b1;
    push_exp(GT, 4);
    @(negedge clk);
    start = 1'b0;
    check("b2b_cleared", 32'({great, equal, less}), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    drain("b2b_timeout");

    // Reset during CMP aborts without a done pulse
    @(negedge clk);
    a = 16'd60000; b = 16'd60000; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", 32'({busy, done, great, equal, less}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_idle", 32'({busy, done, great, equal, less}), 32'd0);
    run(16'd60000, 16'd60000, 1'b0, EQ, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
